// File: rtl/rv32i_multicycle_core.sv
// rv32i_multicycle_core
// Multi-cycle RV32I integer core. It has one byte-wide unified program/data
// memory and a 32x32 register bank. One instruction is in flight at a time,
// and every memory byte moves through a single 8-bit port.
//
// Ports:
//   clk          single clock. The sequencer advances on the rising edge.
//                Memory and register writes commit on the falling edge.
//   rst          asynchronous, active-low reset
//   pc           program counter (resets to 0)
//   fetch_start  high while the sequencer is in F0 (resets to 1)
//   state        current sequencer state encoding (resets to F0 = 0)
//
// Parameters:
//   MEM_BYTES    memory size in bytes. Addresses wrap modulo this size.
//   INIT_FILE    image name; memory starts at zero.
module rv32i_multicycle_core #(
    parameter int MEM_BYTES = 4096,
    parameter     INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    output logic        fetch_start,
    output logic [4:0]  state
);
    localparam int AW = $clog2(MEM_BYTES);

    typedef enum logic [4:0] {
        F0, F1, F2, F3, DEC, LUI, AUIPC, JAL, JR0, JR1,
        BR0, BR1, LD0, LDB, ST0, ST1, STB, AL0, AL1, WB
    } state_t;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_ALI   = 7'b0010011;
    localparam logic [6:0] OP_ALR   = 7'b0110011;

    state_t      r_state;
    logic [31:0] r_pc, r_instr, r_a, r_data, r_result, r_ea;
    logic [1:0]  r_cnt;
    logic        r_memWe, r_rfWe;
    logic [7:0]  r_mem  [MEM_BYTES];
    logic [31:0] r_regs [32];

    // Memory starts at zero.
    initial begin
        for (int i = 0; i < MEM_BYTES; i++) r_mem[i] = 8'h00;
    end

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic        w_alt, w_isR, w_taken;
    logic [31:0] w_immI, w_immS, w_immB, w_immU, w_immJ;
    logic [31:0] w_rs1Val, w_rs2Val, w_aluB, w_aluOut, w_ldNext, w_ldExt;
    logic [31:0] w_memAddr;
    logic [AW-1:0] w_memIdx;
    logic [7:0]  w_memRd, w_memDin;
    logic [1:0]  w_lastIdx;

    assign w_opcode = r_instr[6:0];
    assign w_rd     = r_instr[11:7];
    assign w_f3     = r_instr[14:12];
    assign w_rs1    = r_instr[19:15];
    assign w_rs2    = r_instr[24:20];
    assign w_alt    = r_instr[30];
    assign w_isR    = (w_opcode == OP_ALR);
    assign w_immI   = {{20{r_instr[31]}}, r_instr[31:20]};
    assign w_immS   = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
    assign w_immB   = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
    assign w_immU   = {r_instr[31:12], 12'h000};
    assign w_immJ   = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};

    // x0 is never written, but it is also forced to zero on read.
    assign w_rs1Val = (w_rs1 == 5'd0) ? 32'h0 : r_regs[w_rs1];
    assign w_rs2Val = (w_rs2 == 5'd0) ? 32'h0 : r_regs[w_rs2];

    // Fetch states address through pc. All other states use EA plus the byte index.
    assign w_memAddr = (r_state inside {F0, F1, F2, F3}) ? r_pc : (r_ea + {30'h0, r_cnt});
    assign w_memIdx  = AW'(w_memAddr % 32'(MEM_BYTES));
    assign w_memRd   = r_mem[w_memIdx];

    // Index of the last byte of a transfer: width 1, 2 or 4 bytes.
    assign w_lastIdx = (w_f3[1:0] == 2'd0) ? 2'd0 : (w_f3[1:0] == 2'd1) ? 2'd1 : 2'd3;

    assign w_aluB = w_isR ? w_rs2Val : w_immI;

    // The ALU selects its operation from func3. SUB exists only for R-type.
    // SRA is chosen by bit 30 for both R-type and I-type.
    always_comb begin
        w_aluOut = 32'h0;
        case (w_f3)
            3'd0: w_aluOut = (w_alt && w_isR) ? (r_a - w_aluB) : (r_a + w_aluB);
            3'd1: w_aluOut = r_a << w_aluB[4:0];
            3'd2: w_aluOut = {31'h0, $signed(r_a) < $signed(w_aluB)};
            3'd3: w_aluOut = {31'h0, r_a < w_aluB};
            3'd4: w_aluOut = r_a ^ w_aluB;
            3'd5: w_aluOut = w_alt ? 32'($signed(r_a) >>> w_aluB[4:0]) : (r_a >> w_aluB[4:0]);
            3'd6: w_aluOut = r_a | w_aluB;
            3'd7: w_aluOut = r_a & w_aluB;
            default: w_aluOut = 32'h0;
        endcase
    end

    // Branch condition. rs2 was latched into r_data during BR0.
    always_comb begin
        w_taken = 1'b0;
        case (w_f3)
            3'd0: w_taken = (w_rs1Val == r_data);
            3'd1: w_taken = (w_rs1Val != r_data);
            3'd4: w_taken = ($signed(w_rs1Val) <  $signed(r_data));
            3'd5: w_taken = ($signed(w_rs1Val) >= $signed(r_data));
            3'd6: w_taken = (w_rs1Val <  r_data);
            3'd7: w_taken = (w_rs1Val >= r_data);
            default: w_taken = 1'b0;
        endcase
    end

    // Load assembly: merge the current memory byte into the data word.
    // Extension is applied to the merged word in the same cycle, so the
    // last byte cycle can go straight to WB.
    always_comb begin
        w_ldNext = r_data;
        case (r_cnt)
            2'd0: w_ldNext[7:0]   = w_memRd;
            2'd1: w_ldNext[15:8]  = w_memRd;
            2'd2: w_ldNext[23:16] = w_memRd;
            2'd3: w_ldNext[31:24] = w_memRd;
            default: w_ldNext = r_data;
        endcase
        w_ldExt = w_ldNext;
        case (w_f3)
            3'd0: w_ldExt = {{24{w_ldNext[7]}}, w_ldNext[7:0]};
            3'd1: w_ldExt = {{16{w_ldNext[15]}}, w_ldNext[15:0]};
            3'd4: w_ldExt = {24'h0, w_ldNext[7:0]};
            3'd5: w_ldExt = {16'h0, w_ldNext[15:0]};
            default: w_ldExt = w_ldNext;
        endcase
    end

    // Store byte selection follows the byte index.
    always_comb begin
        w_memDin = 8'h00;
        case (r_cnt)
            2'd0: w_memDin = r_data[7:0];
            2'd1: w_memDin = r_data[15:8];
            2'd2: w_memDin = r_data[23:16];
            2'd3: w_memDin = r_data[31:24];
            default: w_memDin = 8'h00;
        endcase
    end

    // Main sequencer. The write enables are registered here and asserted
    // only while in STB or WB. An async reset drops both enables at once,
    // which stops a store that is in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= F0;
            r_pc     <= 32'h0;
            r_instr  <= 32'h0;
            r_a      <= 32'h0;
            r_data   <= 32'h0;
            r_result <= 32'h0;
            r_ea     <= 32'h0;
            r_cnt    <= 2'd0;
            r_memWe  <= 1'b0;
            r_rfWe   <= 1'b0;
        end else begin
            case (r_state)
                F0:  begin r_instr[7:0]   <= w_memRd; r_pc <= r_pc + 32'd1; r_state <= F1;  end
                F1:  begin r_instr[15:8]  <= w_memRd; r_pc <= r_pc + 32'd1; r_state <= F2;  end
                F2:  begin r_instr[23:16] <= w_memRd; r_pc <= r_pc + 32'd1; r_state <= F3;  end
                F3:  begin r_instr[31:24] <= w_memRd; r_pc <= r_pc + 32'd1; r_state <= DEC; end
                DEC: begin
                    case (w_opcode)
                        OP_LUI:         r_state <= LUI;
                        OP_AUIPC:       r_state <= AUIPC;
                        OP_JAL:         r_state <= JAL;
                        OP_JALR:        r_state <= JR0;
                        OP_BR:          r_state <= BR0;
                        OP_LD:          r_state <= LD0;
                        OP_ST:          r_state <= ST0;
                        OP_ALI, OP_ALR: r_state <= AL0;
                        default:        r_state <= F0;
                    endcase
                end
                LUI:   begin r_result <= w_immU; r_rfWe <= 1'b1; r_state <= WB; end
                AUIPC: begin r_result <= w_immU + r_pc - 32'd4; r_rfWe <= 1'b1; r_state <= WB; end
                JAL: begin
                    r_result <= r_pc;
                    r_pc     <= r_pc - 32'd4 + w_immJ;
                    r_rfWe   <= 1'b1;
                    r_state  <= WB;
                end
                JR0: begin r_a <= w_rs1Val; r_state <= JR1; end
                JR1: begin
                    r_result <= r_pc;
                    r_pc     <= (r_a + w_immI) & ~32'd1;
                    r_rfWe   <= 1'b1;
                    r_state  <= WB;
                end
                BR0: begin r_data <= w_rs2Val; r_state <= BR1; end
                BR1: begin
                    if (w_taken) r_pc <= r_pc - 32'd4 + w_immB;
                    r_state <= F0;
                end
                LD0: begin r_ea <= w_rs1Val + w_immI; r_cnt <= 2'd0; r_state <= LDB; end
                LDB: begin
                    r_data <= w_ldNext;
                    if (r_cnt == w_lastIdx) begin
                        r_result <= w_ldExt;
                        r_rfWe   <= 1'b1;
                        r_state  <= WB;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                ST0: begin r_data <= w_rs2Val; r_state <= ST1; end
                ST1: begin
                    r_ea    <= w_rs1Val + w_immS;
                    r_cnt   <= 2'd0;
                    r_memWe <= 1'b1;
                    r_state <= STB;
                end
                STB: begin
                    if (r_cnt == w_lastIdx) begin
                        r_memWe <= 1'b0;
                        r_state <= F0;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                AL0: begin r_a <= w_rs1Val; r_state <= AL1; end
                AL1: begin r_result <= w_aluOut; r_rfWe <= 1'b1; r_state <= WB; end
                WB:  begin r_rfWe <= 1'b0; r_state <= F0; end
                default: r_state <= F0;
            endcase
        end
    end

    // Memory write port. It commits in the middle of each STB cycle.
    always_ff @(negedge clk) begin
        if (r_memWe) r_mem[w_memIdx] <= w_memDin;
    end

    // Register bank write port. It commits in the middle of WB and drops writes to x0.
    always_ff @(negedge clk) begin
        if (r_rfWe && (w_rd != 5'd0)) r_regs[w_rd] <= r_result;
    end

    assign pc          = r_pc;
    assign fetch_start = (r_state == F0);
    assign state       = r_state;
endmodule

// File: tb/tb_rv32i_multicycle_core.sv
// tb_rv32i_multicycle_core
// Directed bench for rv32i_multicycle_core. Programs and register values
// are placed straight into the core's memory and register bank. The bench
// then counts cycles from one F0 to the next and compares the results
// against hand-computed values.
module tb_rv32i_multicycle_core;
    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        fetch_start;
    logic [4:0]  state;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] OPL = 7'b0000011;

    rv32i_multicycle_core #(.MEM_BYTES(4096), .INIT_FILE("")) dut (
        .clk(clk),
        .rst(rst),
        .pc(pc),
        .fetch_start(fetch_start),
        .state(state)
    );

    // Free-running clock with a 10-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] expRd;
        int          expCycles;
        logic [31:0] expPc;
    } vec_t;

    vec_t vecs[26];

    // Instruction encoders
    function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] encU(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] encJ(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic loadWord(input int addr, input logic [31:0] w);
        for (int k = 0; k < 4; k++) dut.r_mem[addr + k] = w[8*k +: 8];
    endtask

    // Hold reset and clear the memory and register bank
    task automatic clearAll();
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4096; k++) dut.r_mem[k] = 8'h00;
        for (int k = 0; k < 32; k++) dut.r_regs[k] = 32'h0;
    endtask

    // Run one instruction. Count rising edges until the core re-enters F0,
    // stopping after 60 cycles at most.
    task automatic runInstr(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!fetch_start && cycles < 60);
    endtask

    task automatic applyStimulus(input vec_t v, output int cycles);
        clearAll();
        loadWord(0, v.instr);
        dut.r_regs[1] = v.a;
        dut.r_regs[2] = v.b;
        @(negedge clk);
        rst = 1'b1;
        runInstr(cycles);
    endtask

    task automatic checkOutput(input int idx, input vec_t v, input int cycles);
        checkVal($sformatf("vec%0d rd", idx), dut.r_regs[v.rd], v.expRd);
        checkVal($sformatf("vec%0d cycles", idx), 32'(cycles), 32'(v.expCycles));
        checkVal($sformatf("vec%0d pc", idx), pc, v.expPc);
    endtask

    initial begin
        int cyc;

        vecs[0]  = '{encU(20'h12345, 3, 7'b0110111), 32'h0, 32'h0, 5'd3, 32'h12345000, 7, 32'h4};
        vecs[1]  = '{encU(20'h00001, 3, 7'b0010111), 32'h0, 32'h0, 5'd3, 32'h00001000, 7, 32'h4};
        vecs[2]  = '{encI(12'hFFB, 0, 3'd0, 3, OPI), 32'h0, 32'h0, 5'd3, 32'hFFFFFFFB, 8, 32'h4};
        vecs[3]  = '{encI(12'h401, 1, 3'd5, 3, OPI), 32'hFFFFFFFB, 32'h0, 5'd3, 32'hFFFFFFFD, 8, 32'h4};
        vecs[4]  = '{encI(12'h01C, 1, 3'd5, 3, OPI), 32'hFFFFFFFB, 32'h0, 5'd3, 32'h0000000F, 8, 32'h4};
        vecs[5]  = '{encR(7'h00, 2, 0, 3'd3, 3), 32'h0, 32'hFFFFFFFB, 5'd3, 32'h1, 8, 32'h4};
        vecs[6]  = '{encR(7'h20, 2, 1, 3'd0, 3), 32'd5, 32'd7, 5'd3, 32'hFFFFFFFE, 8, 32'h4};
        vecs[7]  = '{encR(7'h00, 2, 1, 3'd2, 3), 32'hFFFFFFFF, 32'd1, 5'd3, 32'h1, 8, 32'h4};
        vecs[8]  = '{encR(7'h00, 2, 1, 3'd7, 3), 32'h0000F0F0, 32'h0000FF00, 5'd3, 32'h0000F000, 8, 32'h4};
        vecs[9]  = '{encR(7'h00, 2, 1, 3'd1, 3), 32'd1, 32'd33, 5'd3, 32'h2, 8, 32'h4};
        vecs[10] = '{encR(7'h20, 2, 1, 3'd5, 3), 32'h80000000, 32'd4, 5'd3, 32'hF8000000, 8, 32'h4};
        vecs[11] = '{encR(7'h00, 2, 1, 3'd0, 3), 32'hFFFFFFFF, 32'd2, 5'd3, 32'h1, 8, 32'h4};
        vecs[12] = '{encI(12'hFFF, 1, 3'd4, 3, OPI), 32'h0F0F0F0F, 32'h0, 5'd3, 32'hF0F0F0F0, 8, 32'h4};
        vecs[13] = '{encI(12'h7FF, 1, 3'd6, 3, OPI), 32'h00001000, 32'h0, 5'd3, 32'h000017FF, 8, 32'h4};
        vecs[14] = '{encI(12'hFFF, 1, 3'd2, 3, OPI), 32'hFFFFFFFE, 32'h0, 5'd3, 32'h1, 8, 32'h4};
        vecs[15] = '{encI(12'h007, 0, 3'd0, 0, OPI), 32'h0, 32'h0, 5'd0, 32'h0, 8, 32'h4};
        vecs[16] = '{encB(13'd8, 1, 1, 3'd5), 32'd5, 32'h0, 5'd3, 32'h0, 7, 32'h8};
        vecs[17] = '{encB(13'd8, 1, 1, 3'd1), 32'd5, 32'h0, 5'd3, 32'h0, 7, 32'h4};
        vecs[18] = '{encB(13'h1FFC, 2, 1, 3'd6), 32'd1, 32'hFFFFFFFF, 5'd3, 32'h0, 7, 32'hFFFFFFFC};
        vecs[19] = '{encB(13'd12, 2, 1, 3'd0), 32'd5, 32'd5, 5'd3, 32'h0, 7, 32'hC};
        vecs[20] = '{encB(13'd16, 2, 1, 3'd4), 32'hFFFFFFFF, 32'd1, 5'd3, 32'h0, 7, 32'h10};
        vecs[21] = '{encB(13'd16, 2, 1, 3'd7), 32'd1, 32'hFFFFFFFF, 5'd3, 32'h0, 7, 32'h4};
        vecs[22] = '{encJ(21'd16, 3), 32'h0, 32'h0, 5'd3, 32'h4, 7, 32'h10};
        vecs[23] = '{encI(12'h003, 0, 3'd0, 3, 7'b1100111), 32'h0, 32'h0, 5'd3, 32'h4, 8, 32'h2};
        vecs[24] = '{32'h00000000, 32'h0, 32'h0, 5'd3, 32'h0, 5, 32'h4};
        vecs[25] = '{32'h0000000F, 32'h0, 32'h0, 5'd3, 32'h0, 5, 32'h4};

        // Reset state
        rst = 1'b0;
        #12;
        checkVal("reset pc", pc, 32'h0);
        checkVal("reset fetch_start", {31'h0, fetch_start}, 32'h1);
        checkVal("reset state", {27'h0, state}, 32'h0);

        // Single-instruction vectors
        for (int i = 0; i < 26; i++) begin
            applyStimulus(vecs[i], cyc);
            checkOutput(i, vecs[i], cyc);
        end

        // Eight zero-word NOPs, then JAL x1,+16 at 0x20
        clearAll();
        loadWord(32'h20, encJ(21'd16, 1));
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 9; k++) runInstr(cyc);
        checkVal("jal@20 x1", dut.r_regs[1], 32'h24);
        checkVal("jal@20 pc", pc, 32'h30);

        // Store and then load back with widths and sign handling
        clearAll();
        loadWord(0,  encS(12'h000, 6, 7, 3'd2));
        loadWord(4,  encI(12'h000, 7, 3'd0, 8, OPL));
        loadWord(8,  encI(12'h000, 7, 3'd4, 9, OPL));
        loadWord(12, encI(12'h001, 7, 3'd1, 10, OPL));
        loadWord(16, encI(12'h000, 7, 3'd2, 11, OPL));
        dut.r_regs[6] = 32'hDEADBE80;
        dut.r_regs[7] = 32'h00000100;
        @(negedge clk);
        rst = 1'b1;
        runInstr(cyc);
        checkVal("sw cycles", 32'(cyc), 32'd11);
        checkVal("sw mem word", {dut.r_mem[259], dut.r_mem[258], dut.r_mem[257], dut.r_mem[256]}, 32'hDEADBE80);
        runInstr(cyc);
        checkVal("lb cycles", 32'(cyc), 32'd8);
        checkVal("lb x8", dut.r_regs[8], 32'hFFFFFF80);
        runInstr(cyc);
        checkVal("lbu x9", dut.r_regs[9], 32'h00000080);
        runInstr(cyc);
        checkVal("lh cycles", 32'(cyc), 32'd9);
        checkVal("lh x10", dut.r_regs[10], 32'hFFFFADBE);
        runInstr(cyc);
        checkVal("lw cycles", 32'(cyc), 32'd11);
        checkVal("lw x11", dut.r_regs[11], 32'hDEADBE80);
        checkVal("ld pc", pc, 32'h14);

        // Reset during the second STB cycle of a store
        clearAll();
        loadWord(0, encS(12'h000, 6, 7, 3'd2));
        dut.r_regs[6] = 32'hA1B2C3D4;
        dut.r_regs[7] = 32'h00000200;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkVal("midstore pc", pc, 32'h0);
        checkVal("midstore state", {27'h0, state}, 32'h0);
        checkVal("midstore fetch_start", {31'h0, fetch_start}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkVal("midstore byte0", {24'h0, dut.r_mem[512]}, 32'h000000D4);
        checkVal("midstore byte1", {24'h0, dut.r_mem[513]}, 32'h00000000);
        rst = 1'b1;
        runInstr(cyc);
        checkVal("restart sw cycles", 32'(cyc), 32'd11);
        checkVal("restart pc", pc, 32'h4);
        checkVal("restart mem word", {dut.r_mem[515], dut.r_mem[514], dut.r_mem[513], dut.r_mem[512]}, 32'hA1B2C3D4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
